// File: rtl/router_fsm_ctrl.sv
// Write-side packet control FSM for the 1x3 router: header decode, payload and
// parity load sequencing, full-FIFO stalls and per-port read-timeout recovery.
module router_fsm_ctrl (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state;
    logic [1:0] addr_q;
    logic       hdr_empty;
    logic       sel_empty;
    logic       sel_soft_reset;

    // Address 3 selects no port, so it never matches an empty flag or soft reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hdr_empty      = 1'b0;
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
        case (data_in)
            2'd0:    hdr_empty = fifo_empty_0;
            2'd1:    hdr_empty = fifo_empty_1;
            2'd2:    hdr_empty = fifo_empty_2;
            default: hdr_empty = 1'b0;
        endcase
        case (addr_q)
            2'd0: begin
                sel_empty      = fifo_empty_0;
                sel_soft_reset = soft_reset_0;
            end
            2'd1: begin
                sel_empty      = fifo_empty_1;
                sel_soft_reset = soft_reset_1;
            end
            2'd2: begin
                sel_empty      = fifo_empty_2;
                sel_soft_reset = soft_reset_2;
            end
            default: begin
                sel_empty      = 1'b0;
                sel_soft_reset = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= 2'd0;
        end else begin
            if (state == DECODE_ADDRESS && pkt_valid)
                addr_q <= data_in;

            if (state != DECODE_ADDRESS && sel_soft_reset) begin
                state <= DECODE_ADDRESS;
            end else begin
                case (state)
                    DECODE_ADDRESS: begin
                        if (pkt_valid && data_in != 2'd3)
                            state <= hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                    WAIT_TILL_EMPTY: begin
                        if (sel_empty)
                            state <= LOAD_FIRST_DATA;
                    end
                    LOAD_FIRST_DATA: state <= LOAD_DATA;
                    LOAD_DATA: begin
                        // A full FIFO must be serviced before the packet can close.
                        if (fifo_full)
                            state <= FIFO_FULL_STATE;
                        else if (!pkt_valid)
                            state <= LOAD_PARITY;
                    end
                    FIFO_FULL_STATE: begin
                        if (!fifo_full)
                            state <= LOAD_AFTER_FULL;
                    end
                    LOAD_AFTER_FULL: begin
                        if (parity_done)
                            state <= DECODE_ADDRESS;
                        else if (low_pkt_valid)
                            state <= LOAD_PARITY;
                        else
                            state <= LOAD_DATA;
                    end
                    LOAD_PARITY: state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    end
                    default: state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    // Moore outputs: pure decode of the state register.
    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Scoreboard bench for router_fsm_ctrl: each scenario table pushes the expected
// output word when its stimulus is driven and compares it after the clock edge.
module tb_router_fsm_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, write_enb_reg, busy;

    router_fsm_ctrl dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Output word: {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    localparam logic [7:0] S_DA   = 8'b1000_0000;
    localparam logic [7:0] S_LFD  = 8'b0100_0001;
    localparam logic [7:0] S_LD   = 8'b0010_0010;
    localparam logic [7:0] S_LAF  = 8'b0001_0011;
    localparam logic [7:0] S_FULL = 8'b0000_1001;
    localparam logic [7:0] S_CPE  = 8'b0000_0101;
    localparam logic [7:0] S_LP   = 8'b0000_0011;
    localparam logic [7:0] S_WTE  = 8'b0000_0001;

    typedef struct packed {
        logic       rstn;
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] empty;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } step_t;

    logic [7:0] outs;
    assign outs = {detect_add, lfd_state, ld_state, laf_state,
                   full_state, rst_int_reg, write_enb_reg, busy};

    logic [7:0] sb[$];
    step_t      steps[$];
    logic [7:0] exp_w;
    int         checks = 0;
    int         errors = 0;

    function automatic step_t mk(logic rstn, logic pv, logic [1:0] din, logic full,
                                 logic [2:0] empty, logic [2:0] sr, logic pd,
                                 logic lpv, logic [7:0] exp);
        step_t s;
        s.rstn = rstn; s.pv = pv; s.din = din; s.full = full; s.empty = empty;
        s.sr = sr; s.pd = pd; s.lpv = lpv; s.exp = exp;
        return s;
    endfunction

    // Drives one cycle of stimulus and records what the outputs must be after the edge.
    task automatic drive(input step_t s);
        resetn        = s.rstn;
        pkt_valid     = s.pv;
        data_in       = s.din;
        fifo_full     = s.full;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = s.empty;
        {soft_reset_2, soft_reset_1, soft_reset_0} = s.sr;
        parity_done   = s.pd;
        low_pkt_valid = s.lpv;
        sb.push_back(s.exp);
    endtask

    task automatic test_reset();
        steps.delete();
        steps.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
        steps.push_back(mk(0, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
        steps.push_back(mk(1, 0, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_DA));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(posedge clock); #1;
            exp_w = sb.pop_front();
            checks++;
            if (outs !== exp_w) begin
                errors++;
                $display("FAIL reset step %0d: got %b want %b", i, outs, exp_w);
            end
        end
    endtask

    task automatic test_normal_packet();
        steps.delete();
        steps.push_back(mk(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LFD));
        for (int k = 0; k < 4; k++)
            steps.push_back(mk(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_LD));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(posedge clock); #1;
            exp_w = sb.pop_front();
            checks++;
            if (outs !== exp_w) begin
                errors++;
                $display("FAIL normal_packet step %0d: got %b want %b", i, outs, exp_w);
            end
        end
    endtask

    task automatic test_busy_destination();
        steps.delete();
        for (int k = 0; k < 5; k++)
            steps.push_back(mk(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, S_WTE));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(posedge clock); #1;
            exp_w = sb.pop_front();
            checks++;
            if (outs !== exp_w) begin
                errors++;
                $display("FAIL busy_destination step %0d: got %b want %b", i, outs, exp_w);
            end
        end
    endtask

    task automatic test_full_stall();
        steps.delete();
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
        for (int k = 0; k < 3; k++)
            steps.push_back(mk(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
        // fifo_full outranks the end of the packet in LOAD_DATA
        steps.push_back(mk(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 1, S_LP));
        steps.push_back(mk(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_CPE));
        steps.push_back(mk(1, 0, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LAF));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 1, 1, S_DA));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(posedge clock); #1;
            exp_w = sb.pop_front();
            checks++;
            if (outs !== exp_w) begin
                errors++;
                $display("FAIL full_stall step %0d: got %b want %b", i, outs, exp_w);
            end
        end
    endtask

    task automatic test_soft_reset();
        steps.delete();
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
        steps.push_back(mk(1, 1, 2'd0, 1, 3'b111, 3'b000, 0, 0, S_FULL));
        steps.push_back(mk(1, 1, 2'd0, 1, 3'b111, 3'b010, 0, 0, S_FULL));
        steps.push_back(mk(1, 1, 2'd0, 1, 3'b111, 3'b100, 0, 0, S_FULL));
        steps.push_back(mk(1, 1, 2'd0, 1, 3'b111, 3'b001, 0, 0, S_DA));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b001, 0, 0, S_DA));
        // Soft reset of the selected port also aborts a wait for an empty FIFO
        steps.push_back(mk(1, 1, 2'd2, 0, 3'b011, 3'b000, 0, 0, S_WTE));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b011, 3'b001, 0, 0, S_WTE));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b011, 3'b100, 0, 0, S_DA));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(posedge clock); #1;
            exp_w = sb.pop_front();
            checks++;
            if (outs !== exp_w) begin
                errors++;
                $display("FAIL soft_reset step %0d: got %b want %b", i, outs, exp_w);
            end
        end
    endtask

    task automatic test_invalid_address();
        steps.delete();
        for (int k = 0; k < 4; k++)
            steps.push_back(mk(1, 1, 2'd3, 0, 3'b111, 3'b000, 0, 0, S_DA));
        steps.push_back(mk(1, 1, 2'd3, 0, 3'b111, 3'b111, 0, 0, S_DA));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(posedge clock); #1;
            exp_w = sb.pop_front();
            checks++;
            if (outs !== exp_w) begin
                errors++;
                $display("FAIL invalid_address step %0d: got %b want %b", i, outs, exp_w);
            end
        end
    endtask

    task automatic test_mid_packet_reset();
        steps.delete();
        steps.push_back(mk(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LFD));
        steps.push_back(mk(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_LD));
        steps.push_back(mk(0, 1, 2'd1, 1, 3'b111, 3'b000, 0, 0, S_DA));
        steps.push_back(mk(1, 0, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_DA));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(posedge clock); #1;
            exp_w = sb.pop_front();
            checks++;
            if (outs !== exp_w) begin
                errors++;
                $display("FAIL mid_packet_reset step %0d: got %b want %b", i, outs, exp_w);
            end
        end
    endtask

    task automatic test_back_to_back();
        steps.delete();
        steps.push_back(mk(1, 1, 2'd2, 0, 3'b111, 3'b000, 0, 0, S_LFD));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LD));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LP));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_CPE));
        steps.push_back(mk(1, 1, 2'd1, 0, 3'b111, 3'b000, 0, 0, S_DA));
        steps.push_back(mk(1, 1, 2'd1, 0, 3'b101, 3'b000, 0, 0, S_WTE));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_LFD));
        steps.push_back(mk(1, 1, 2'd0, 0, 3'b111, 3'b010, 0, 0, S_DA));
        steps.push_back(mk(1, 0, 2'd0, 0, 3'b111, 3'b000, 0, 0, S_DA));
        foreach (steps[i]) begin
            drive(steps[i]);
            @(posedge clock); #1;
            exp_w = sb.pop_front();
            checks++;
            if (outs !== exp_w) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b want %b", i, outs, exp_w);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        test_reset();
        test_normal_packet();
        test_busy_destination();
        test_full_stall();
        test_soft_reset();
        test_invalid_address();
        test_mid_packet_reset();
        test_back_to_back();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fsm_ctrl.md
Name: router_fsm_ctrl

Overview:
Packet-level control FSM for the 1x3 router's write side. It decodes the header, sequences header, payload and parity loads, and stalls on full destination FIFOs. It drives the synchronizer's detect_add and write_enb_reg, and consumes its fifo_full and soft_reset_0..2. It also drives the register block's load and parity strobes and the busy flow-control output back to the source.

Parameters:
none (port count fixed at 3, address width 2)

Ports:
clock  input  1  system clock, all state on rising edge
resetn  input  1  synchronous, active-low reset
pkt_valid  input  1  source packet framing; high from header through last payload byte
data_in  input  2  header address bits [1:0] from the input bus
fifo_full  input  1  full flag of the currently selected FIFO (from synchronizer)
fifo_empty_0  input  1  empty flag, FIFO 0
fifo_empty_1  input  1  empty flag, FIFO 1
fifo_empty_2  input  1  empty flag, FIFO 2
soft_reset_0  input  1  read-timeout reset, port 0
soft_reset_1  input  1  read-timeout reset, port 1
soft_reset_2  input  1  read-timeout reset, port 2
parity_done  input  1  register block has captured the parity byte
low_pkt_valid  input  1  register block saw pkt_valid fall while the FIFO was full
detect_add  output  1  high in DECODE_ADDRESS
lfd_state  output  1  high in LOAD_FIRST_DATA
ld_state  output  1  high in LOAD_DATA
laf_state  output  1  high in LOAD_AFTER_FULL
full_state  output  1  high in FIFO_FULL_STATE
rst_int_reg  output  1  high in CHECK_PARITY_ERROR
write_enb_reg  output  1  high in LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL
busy  output  1  source stall; low only in DECODE_ADDRESS and LOAD_DATA

Behaviour:
- Reset: resetn=0 at a clock edge sets state to DECODE_ADDRESS and addr_q to 0. Takes effect mid-packet as well.
- After reset: detect_add=1; all other outputs 0.
- Outputs are Moore: decoded combinationally from the state register only, with no input-to-output paths.
- addr_q (2-bit register) captures data_in on any edge where state==DECODE_ADDRESS and pkt_valid=1. It holds otherwise.
- Transitions, evaluated at each edge:
  - DECODE_ADDRESS: pkt_valid=1, data_in=k (k in 0..2), fifo_empty_k=1 -> LOAD_FIRST_DATA.
  - DECODE_ADDRESS: pkt_valid=1, data_in=k, fifo_empty_k=0 -> WAIT_TILL_EMPTY.
  - DECODE_ADDRESS: data_in=3 or pkt_valid=0 -> stay.
  - WAIT_TILL_EMPTY: fifo_empty[addr_q]=1 -> LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA: -> LOAD_DATA unconditionally (exactly 1 cycle).
  - LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE. Else pkt_valid=0 -> LOAD_PARITY. Else stay. fifo_full has priority over pkt_valid=0.
  - FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS. Else low_pkt_valid=1 -> LOAD_PARITY. Else -> LOAD_DATA.
  - LOAD_PARITY: -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Soft reset: soft_reset[addr_q]=1 forces next state DECODE_ADDRESS from any state except DECODE_ADDRESS. It takes priority over all transitions above; only resetn outranks it.
- Soft resets of non-selected ports are ignored.
- Encoding: 3-bit binary state register. Illegal encodings recover to DECODE_ADDRESS on the next edge.
- Header-to-first-write latency when the target FIFO is empty:
  - header edge: DECODE_ADDRESS -> LOAD_FIRST_DATA;
  - next cycle: lfd_state=1;
  - cycle after: ld_state=1 and write_enb_reg=1.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, pkt_valid=0 -> detect_add=1, busy=0, write_enb_reg=0; state holds DECODE_ADDRESS.
- Normal packet to port 1: pkt_valid=1, data_in=2'b01, fifo_empty_1=1, 4 payload cycles, then pkt_valid=0 -> lfd_state=1 for 1 cycle; ld_state=1 for 4 cycles; LOAD_PARITY (write_enb_reg=1, busy=1) for 1 cycle; rst_int_reg=1 for 1 cycle; then detect_add=1.
- Busy destination: header data_in=2'b10 with fifo_empty_2=0 for 5 cycles -> busy=1 and write_enb_reg=0 for 5 cycles; lfd_state=1 the cycle after fifo_empty_2 rises.
- Full stall: in LOAD_DATA assert fifo_full for 3 cycles -> full_state=1, busy=1, write_enb_reg=0 for 3 cycles; then laf_state=1 for 1 cycle. With parity_done=0 and low_pkt_valid=0, state returns to LOAD_DATA.
- Soft reset: packet to port 0 held in FIFO_FULL_STATE; pulse soft_reset_1 -> no effect. Pulse soft_reset_0 -> detect_add=1 on the next cycle.
- Invalid address: pkt_valid=1, data_in=2'b11 for 4 cycles -> detect_add stays 1; lfd_state and busy stay 0.
